// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op-codes, FSM
// states and default widths used by the unit, its interface and the decoder.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MLA  = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the control FSM (master) and the
// multiply/divide unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b, src_c,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b, src_c,
    output busy, done, result, div_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step (LSB first)
// or a restoring-division step (MSB first), chosen by is_div.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             q_bit;

  // Remainder stays below the divisor, so the low WIDTH bits of the
  // difference are exact whenever a subtraction is taken.
  always_comb begin
    rem_sh = {acc, a[WIDTH-1]};
    diff   = rem_sh[WIDTH-1:0] - b;
    q_bit  = (rem_sh >= {1'b0, b});
    if (is_div) begin
      acc_nxt = q_bit ? diff : rem_sh[WIDTH-1:0];
      a_nxt   = {a[WIDTH-2:0], q_bit};
      b_nxt   = b;
    end else begin
      acc_nxt = b[0] ? (acc + a) : acc;
      a_nxt   = a << 1;
      b_nxt   = b >> 1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MLA/UDIV/SDIV unit with a fixed latency of WIDTH+2 cycles
// from the accepted start edge to the done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  // RUN spends one extra cycle at the terminal count before FIX; this is
  // what makes the latency WIDTH+2 and why the counter must reach WIDTH.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic             neg_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] result_q;
  logic             div_zero_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] fix_result;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             load;
  logic             step;
  logic             fix;
  logic             busy;
  logic             done;
  logic             is_div;
  logic             b_zero;

  assign is_div = op_is_div(op_q);
  assign b_zero = (b_q == '0);
  assign a_mag  = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
  assign b_mag  = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div),
    .acc     (acc_q),
    .a       (a_q),
    .b       (b_q),
    .acc_nxt (acc_nxt),
    .a_nxt   (a_nxt),
    .b_nxt   (b_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = (state == IDLE) && bus.start;
    step = (state == RUN) && (cnt_q != LAST_CNT);
    fix  = (state == FIX);
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // SDIV runs on magnitudes; the quotient sign is restored in FIX.
  always_comb begin
    fix_result = acc_q;
    case (op_q)
      OP_MUL:  fix_result = acc_q;
      OP_MLA:  fix_result = acc_q + c_q;
      OP_UDIV: fix_result = b_zero ? '0 : a_q;
      OP_SDIV: fix_result = b_zero ? '0 : (neg_q ? -a_q : a_q);
      default: fix_result = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      if (load) begin
        op_q  <= bus.op;
        cnt_q <= '0;
        acc_q <= '0;
        c_q   <= bus.src_c;
        if (bus.op == OP_SDIV) begin
          a_q   <= a_mag;
          b_q   <= b_mag;
          neg_q <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
        end else begin
          a_q   <= bus.src_a;
          b_q   <= bus.src_b;
          neg_q <= 1'b0;
        end
      end else if (step) begin
        acc_q <= acc_nxt;
        a_q   <= a_nxt;
        b_q   <= b_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fix) begin
        result_q   <= fix_result;
        div_zero_q <= is_div && b_zero;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  // Start driven at negedge k is sampled at the next edge; done is visible
  // at the negedge k + W + 3.
  localparam int LAT = W + 3;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb_q[$];

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cycle = 0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void ref_model(input op_e op, input logic [W-1:0] a, b, c,
                                    output logic [W-1:0] r, output logic dz);
    longint sa;
    longint sb;
    longint q;
    dz = 1'b0;
    r  = '0;
    case (op)
      OP_MUL: r = a * b;
      OP_MLA: r = a * b + c;
      OP_UDIV: begin
        if (b == 0) dz = 1'b1;
        else r = a / b;
      end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = q[W-1:0];
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rand_b();
    case ($urandom_range(0, 7))
      0:       return '0;
      1, 2:    return W'($urandom_range(1, 20));
      3:       return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic apply_stimulus(input op_e op, input logic [W-1:0] a, b, c, input bit accept);
    exp_t         e;
    logic [W-1:0] r;
    logic         dz;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.src_c = c;
    if (accept) begin
      ref_model(op, a, b, c, r, dz);
      e.res = r;
      e.dz  = dz;
      e.due = cycle + LAT;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = op_e'($urandom_range(0, 3));
    bus.src_a = W'($urandom);
    bus.src_b = W'($urandom);
    bus.src_c = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL idle_timeout: busy still %b after %0d cycles, expected 0", bus.busy, n);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done !== 1'b0) begin
      if (sb_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL spurious_done: got done=%b at cycle %0d, expected no done", bus.done, cycle);
      end else begin
        e = sb_q.pop_front();
        check_output("result", bus.result, e.res);
        check_output("div_zero", W'(bus.div_zero), W'(e.dz));
        check_output("latency", W'(cycle), W'(e.due));
        check_output("busy_at_done", W'(bus.busy), W'(1));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   k;
    int   r;
    op_e  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;

    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.src_c = '0;

    repeat (3) @(negedge clk);
    check_output("reset_busy", W'(bus.busy), '0);
    check_output("reset_done", W'(bus.done), '0);
    check_output("reset_result", bus.result, '0);
    check_output("reset_div_zero", W'(bus.div_zero), '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] directed: MUL 7*6 with busy tracking");
    k = cycle;
    apply_stimulus(OP_MUL, 7, 6, 0, 1);
    while (cycle < k + LAT) begin
      check_output("busy_run", W'(bus.busy), W'(1));
      @(negedge clk);
    end
    wait_idle();

    apply_stimulus(OP_MLA, 32'hFFFF_FFFF, 2, 5, 1);
    wait_idle();
    apply_stimulus(OP_SDIV, -32'd7, 2, 0, 1);
    wait_idle();
    apply_stimulus(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
    wait_idle();
    apply_stimulus(OP_UDIV, 100, 0, 0, 1);
    wait_idle();
    apply_stimulus(OP_UDIV, 100, 7, 0, 1);
    wait_idle();

    $display("[TB] directed: start while busy, start with done, restart after done");
    k = cycle;
    apply_stimulus(OP_MUL, 11, 13, 0, 1);
    while (cycle < k + 6) @(negedge clk);
    apply_stimulus(OP_UDIV, 55, 5, 0, 0);
    while (cycle < k + LAT) @(negedge clk);
    apply_stimulus(OP_MLA, 2, 3, 4, 0);
    apply_stimulus(OP_UDIV, 1000, 9, 0, 1);
    wait_idle();

    $display("[TB] directed: reset in the middle of a UDIV");
    k = cycle;
    apply_stimulus(OP_UDIV, 12345, 17, 0, 0);
    while (cycle < k + 11) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("midreset_busy", W'(bus.busy), '0);
    check_output("midreset_done", W'(bus.done), '0);
    check_output("midreset_result", bus.result, '0);
    check_output("midreset_div_zero", W'(bus.div_zero), '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(OP_MUL, 3, 3, 0, 1);
    wait_idle();

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      op = op_e'($urandom_range(0, 3));
      a  = W'($urandom);
      b  = rand_b();
      c  = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      k = cycle;
      apply_stimulus(op, a, b, c, 1);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 34);
        while (cycle < k + 1 + r) @(negedge clk);
        apply_stimulus(op_e'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
      end else begin
        while (cycle < k + LAT + 1) @(negedge clk);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check_output("pending_requests", W'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
